rs_alu: RTL and testbench
=========================

Name: rs_alu

Overview:
- 4-entry reservation station plus integer ALU on the consumer side of the reorder buffer's dispatch interface.
- Accepts dispatched ops tagged with a ROB index and holds them until both operands are ready.
- Operands become ready by snooping its own result bus and the memory result bus.
- Issues one op per cycle and returns the tagged result on alu_num/alu_value, the bus the ROB writes back from.

Parameters:
- DEPTH, 4, number of station entries (power of two, ≥2)
- TAGW, 3, ROB tag width; tag 0 means "no tag / value valid"

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low; clock clk
- op_in  in  5  dispatched opcode; 5'b11111 = no dispatch this cycle
- value1_in  in  32  operand 1 value
- value2_in  in  32  operand 2 value (ROB has already substituted imm where needed)
- query1_in  in  TAGW  operand 1 producer tag; 0 = value1_in valid
- query2_in  in  TAGW  operand 2 producer tag; 0 = value2_in valid
- target_in  in  TAGW  ROB index of the dispatched op
- imm_in  in  32  immediate (used by JALR target)
- mem_num  in  TAGW  memory result tag; 0 = none
- mem_value  in  32  memory result value
- flush  in  1  discard all entries and any pending result
- rs_full  out  1  registered; 1 when free entries ≤ 1
- alu_num  out  TAGW  result tag; 0 = no result this cycle
- alu_value  out  32  result value

Behaviour:
- Reset (rst==0 at posedge): all entries invalid, alu_num=0, alu_value=0, rs_full=0. Reset overrides dispatch, issue and flush.
- Accepted ops: ADD, AND, OR, SLL, SRL, SLT, SLTU, SRA, SUB, XOR, BEQ, BGE, BNE, BGEU, BLT, BLTU, JALR; encodings are the codebase opcode set. Any other op_in, including 5'b11111, allocates nothing.
- Dispatch: at a posedge with an accepted op, write it into the lowest-index free entry. If no entry is free, drop the op and hold an internal overflow flag for verification. The upstream must not dispatch while rs_full=1.
- Dispatch-cycle capture: if query1_in or query2_in is nonzero and equals mem_num or the current alu_num at that edge, store the broadcast value with tag 0.
- Snoop: every posedge, each valid entry whose pending tag equals nonzero alu_num or mem_num latches that value and clears the tag. If both buses carry the same tag, mem wins.
- Issue: at each posedge, select the lowest-index valid entry with both tags 0 that was not written at this same edge. Register alu_num=target and alu_value=result, and free the entry.
  - If no entry is ready, alu_num=0 and alu_value holds its previous value.
  - Result is visible for exactly one cycle per issue.
  - Minimum dispatch-to-result: 2 posedges.
- Freed entry reuse: an entry freed at an edge may be reallocated at the same edge.
- Arithmetic, with a = operand 1 and b = operand 2:
  - ADD/SUB/AND/OR/XOR: mod 2^32.
  - SLL/SRL/SRA: shift by b[4:0].
  - SLT: signed compare; SLTU: unsigned compare; result 1 or 0.
  - Branches: result 1 if taken, else 0. BGE/BLT are signed, BGEU/BLTU unsigned.
  - JALR: result (a + imm_in stored at dispatch) & 32'hFFFFFFFE.
- rs_full: registered each posedge from post-update occupancy; 1 when occupancy ≥ DEPTH−1, else 0.
- Flush (rst==1, flush==1): invalidate all entries, alu_num=0, rs_full=0. A dispatch in the same cycle is discarded. Flush has priority over issue.
- Tags: entries never hold tag 0 as pending. Wrap of ROB indices is opaque to this block.

Test Plan:
1. Reset, then dispatch ADD v1=5, v2=7, tags 0, target=3 → alu_num=3, alu_value=12 two posedges after dispatch, then alu_num=0 the next cycle.
2. Dispatch SUB target=4 with query1=2, value2=1. Drive mem_num=2, mem_value=10 three cycles later → alu_num=4, alu_value=9 one posedge after the snoop edge; no issue before it.
3. Dispatch BLT a=32'hFFFFFFFF, b=1 target=5, then BLTU same operands target=6 → alu_value=1 for tag 5, then 0 for tag 6, on consecutive cycles.
4. Dispatch four dependent ops with query tags 1 and none ready → rs_full=1 after the third write. Broadcast mem_num=1 → the lowest-index entry issues first and rs_full drops after the occupancy falls below 3.
5. Dispatch with query1_in equal to the alu_num on the same edge → the operand is captured and the op issues on the next edge.
6. Fill two ready entries, then assert flush for one cycle → alu_num stays 0 afterwards and rs_full=0. Also check that rst=0 mid-stream clears everything at that posedge.

Source files
------------

// File: rtl/rs_alu_if.sv
// Dispatch, broadcast and result signals between the ROB (master) and the ALU
// reservation station (slave).
interface rs_alu_if #(
    parameter int TAGW = 3
);
    logic [4:0]      op_in;
    logic [31:0]     value1_in;
    logic [31:0]     value2_in;
    logic [TAGW-1:0] query1_in;
    logic [TAGW-1:0] query2_in;
    logic [TAGW-1:0] target_in;
    logic [31:0]     imm_in;
    logic [TAGW-1:0] mem_num;
    logic [31:0]     mem_value;
    logic            flush;
    logic            rs_full;
    logic [TAGW-1:0] alu_num;
    logic [31:0]     alu_value;
    logic            rs_overflow;

    modport master (
        output op_in, value1_in, value2_in, query1_in, query2_in, target_in,
               imm_in, mem_num, mem_value, flush,
        input  rs_full, alu_num, alu_value, rs_overflow
    );

    modport slave (
        input  op_in, value1_in, value2_in, query1_in, query2_in, target_in,
               imm_in, mem_num, mem_value, flush,
        output rs_full, alu_num, alu_value, rs_overflow
    );
endinterface

// File: rtl/rs_alu.sv
// Reservation station plus integer ALU: holds dispatched ops until both operands
// are resolved by snooping the ALU and memory result buses, then issues one per cycle.
module rs_alu #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 3
) (
    input logic   clk,
    input logic   rst,
    rs_alu_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_BEQ  = 5'd10;
    localparam logic [4:0] OP_BNE  = 5'd11;
    localparam logic [4:0] OP_BLT  = 5'd12;
    localparam logic [4:0] OP_BGE  = 5'd13;
    localparam logic [4:0] OP_BLTU = 5'd14;
    localparam logic [4:0] OP_BGEU = 5'd15;
    localparam logic [4:0] OP_JALR = 5'd16;

    logic [DEPTH-1:0] valid_q;
    logic [4:0]       op_q  [DEPTH];
    logic [31:0]      v1_q  [DEPTH];
    logic [31:0]      v2_q  [DEPTH];
    logic [31:0]      imm_q [DEPTH];
    logic [TAGW-1:0]  q1_q  [DEPTH];
    logic [TAGW-1:0]  q2_q  [DEPTH];
    logic [TAGW-1:0]  tgt_q [DEPTH];

    logic             issue_en;
    logic [IW-1:0]    issue_idx;
    logic             alloc_ok;
    logic [IW-1:0]    alloc_idx;
    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] next_valid;
    logic [IW:0]      occ;
    logic             dispatch;
    logic [31:0]      cap_v1, cap_v2;
    logic [TAGW-1:0]  cap_q1, cap_q2;
    logic [31:0]      op_a, op_b, result;

    assign dispatch = (bus.op_in <= OP_JALR);

    // Issue only looks at registered state, so an entry written this edge waits a cycle.
    always_comb begin
        issue_en  = 1'b0;
        issue_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && q1_q[i] == '0 && q2_q[i] == '0) begin
                issue_en  = 1'b1;
                issue_idx = IW'(i);
            end
        end
        free_vec = ~valid_q;
        if (issue_en)
            free_vec[issue_idx] = 1'b1;
        alloc_ok  = 1'b0;
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                alloc_ok  = 1'b1;
                alloc_idx = IW'(i);
            end
        end
        next_valid = valid_q;
        if (issue_en)
            next_valid[issue_idx] = 1'b0;
        if (dispatch && alloc_ok)
            next_valid[alloc_idx] = 1'b1;
        occ = '0;
        for (int i = 0; i < DEPTH; i++)
            occ = occ + (IW+1)'(next_valid[i]);
    end

    // Operands already being broadcast at the dispatch edge are captured directly.
    always_comb begin
        cap_v1 = bus.value1_in;
        cap_q1 = bus.query1_in;
        if (bus.query1_in != '0 && bus.query1_in == bus.mem_num) begin
            cap_v1 = bus.mem_value;
            cap_q1 = '0;
        end else if (bus.query1_in != '0 && bus.query1_in == bus.alu_num) begin
            cap_v1 = bus.alu_value;
            cap_q1 = '0;
        end
        cap_v2 = bus.value2_in;
        cap_q2 = bus.query2_in;
        if (bus.query2_in != '0 && bus.query2_in == bus.mem_num) begin
            cap_v2 = bus.mem_value;
            cap_q2 = '0;
        end else if (bus.query2_in != '0 && bus.query2_in == bus.alu_num) begin
            cap_v2 = bus.alu_value;
            cap_q2 = '0;
        end
    end

    always_comb begin
        op_a   = v1_q[issue_idx];
        op_b   = v2_q[issue_idx];
        result = '0;
        case (op_q[issue_idx])
            OP_ADD:  result = op_a + op_b;
            OP_SUB:  result = op_a - op_b;
            OP_AND:  result = op_a & op_b;
            OP_OR:   result = op_a | op_b;
            OP_XOR:  result = op_a ^ op_b;
            OP_SLL:  result = op_a << op_b[4:0];
            OP_SRL:  result = op_a >> op_b[4:0];
            OP_SRA:  result = $unsigned($signed(op_a) >>> op_b[4:0]);
            OP_SLT:  result = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_SLTU: result = {31'd0, op_a < op_b};
            OP_BEQ:  result = {31'd0, op_a == op_b};
            OP_BNE:  result = {31'd0, op_a != op_b};
            OP_BLT:  result = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_BGE:  result = {31'd0, $signed(op_a) >= $signed(op_b)};
            OP_BLTU: result = {31'd0, op_a < op_b};
            OP_BGEU: result = {31'd0, op_a >= op_b};
            OP_JALR: result = (op_a + imm_q[issue_idx]) & 32'hFFFF_FFFE;
            default: result = '0;
        endcase
    end

    // Snoop, issue and dispatch all resolve at one edge; memory wins a tag tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q         <= '0;
            bus.alu_num     <= '0;
            bus.alu_value   <= '0;
            bus.rs_full     <= 1'b0;
            bus.rs_overflow <= 1'b0;
        end else if (bus.flush) begin
            valid_q     <= '0;
            bus.alu_num <= '0;
            bus.rs_full <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i]) begin
                    if (q1_q[i] != '0 && q1_q[i] == bus.mem_num) begin
                        v1_q[i] <= bus.mem_value;
                        q1_q[i] <= '0;
                    end else if (q1_q[i] != '0 && q1_q[i] == bus.alu_num) begin
                        v1_q[i] <= bus.alu_value;
                        q1_q[i] <= '0;
                    end
                    if (q2_q[i] != '0 && q2_q[i] == bus.mem_num) begin
                        v2_q[i] <= bus.mem_value;
                        q2_q[i] <= '0;
                    end else if (q2_q[i] != '0 && q2_q[i] == bus.alu_num) begin
                        v2_q[i] <= bus.alu_value;
                        q2_q[i] <= '0;
                    end
                end
            end
            if (issue_en) begin
                valid_q[issue_idx] <= 1'b0;
                bus.alu_num        <= tgt_q[issue_idx];
                bus.alu_value      <= result;
            end else begin
                bus.alu_num <= '0;
            end
            if (dispatch) begin
                if (alloc_ok) begin
                    valid_q[alloc_idx] <= 1'b1;
                    op_q[alloc_idx]    <= bus.op_in;
                    v1_q[alloc_idx]    <= cap_v1;
                    v2_q[alloc_idx]    <= cap_v2;
                    q1_q[alloc_idx]    <= cap_q1;
                    q2_q[alloc_idx]    <= cap_q2;
                    tgt_q[alloc_idx]   <= bus.target_in;
                    imm_q[alloc_idx]   <= bus.imm_in;
                end else begin
                    bus.rs_overflow <= 1'b1;
                end
            end
            bus.rs_full <= (occ >= (IW+1)'(DEPTH - 1));
        end
    end
endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: expected results are queued at dispatch and popped
// as tagged results appear on the ALU bus.
module tb_rs_alu;
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_BEQ  = 5'd10;
    localparam logic [4:0] OP_BNE  = 5'd11;
    localparam logic [4:0] OP_BLT  = 5'd12;
    localparam logic [4:0] OP_BGE  = 5'd13;
    localparam logic [4:0] OP_BLTU = 5'd14;
    localparam logic [4:0] OP_BGEU = 5'd15;
    localparam logic [4:0] OP_JALR = 5'd16;
    localparam logic [4:0] OP_NOP  = 5'd31;

    typedef struct packed {
        logic [2:0]  num;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [4:0]  t_op [15] = '{OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT,
                               OP_SLTU, OP_BEQ, OP_BNE, OP_BGE, OP_BGEU, OP_JALR, OP_ADD};
    logic [31:0] t_a  [15] = '{32'd3, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'd1,
                               32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd7, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'h0000_1001, 32'hFFFF_FFFF};
    logic [31:0] t_b  [15] = '{32'd5, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h23,
                               32'd4, 32'd4, 32'd1, 32'd1, 32'd7, 32'd7, 32'hFFFF_FFFE,
                               32'hFFFF_FFFF, 32'd0, 32'd2};
    logic [31:0] t_imm[15] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                               32'd0, 32'd0, 32'd0, 32'd0, 32'h10, 32'd0};

    rs_alu_if #(.TAGW(3)) bus ();

    rs_alu #(.DEPTH(4), .TAGW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
        logic signed [31:0] sa, sb_;
        sa  = a;
        sb_ = b;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return sa >>> b[4:0];
            OP_SLT:  return (sa < sb_) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_BEQ:  return (a == b) ? 32'd1 : 32'd0;
            OP_BNE:  return (a != b) ? 32'd1 : 32'd0;
            OP_BLT:  return (sa < sb_) ? 32'd1 : 32'd0;
            OP_BGE:  return (sa >= sb_) ? 32'd1 : 32'd0;
            OP_BLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_BGEU: return (a >= b) ? 32'd1 : 32'd0;
            OP_JALR: return (a + imm) & 32'hFFFF_FFFE;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                                 input logic [2:0] q1, input logic [2:0] q2, input logic [2:0] tgt,
                                 input logic [31:0] imm);
        bus.op_in     = op;
        bus.value1_in = v1;
        bus.value2_in = v2;
        bus.query1_in = q1;
        bus.query2_in = q2;
        bus.target_in = tgt;
        bus.imm_in    = imm;
    endtask

    task automatic idle();
        applyStimulus(OP_NOP, 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, 32'd0);
    endtask

    task automatic setMem(input logic [2:0] num, input logic [31:0] val);
        bus.mem_num   = num;
        bus.mem_value = val;
    endtask

    task automatic push(input logic [2:0] num, input logic [31:0] val);
        exp_t e;
        e.num = num;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input bit expect_issue, input string tag);
        exp_t e;
        check({tag, "_issue"}, 32'(bus.alu_num != 3'd0), 32'(expect_issue));
        if (bus.alu_num != 3'd0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL %s_unexpected observed=%0d expected=none", tag, bus.alu_num);
            end else begin
                e = sb.pop_front();
                check({tag, "_num"}, 32'(bus.alu_num), 32'(e.num));
                check({tag, "_value"}, bus.alu_value, e.val);
            end
        end
    endtask

    initial begin
        idle();
        setMem(3'd0, 32'd0);
        bus.flush = 1'b0;

        tick();
        tick();
        check("reset_num", 32'(bus.alu_num), 32'd0);
        check("reset_value", bus.alu_value, 32'd0);
        check("reset_full", 32'(bus.rs_full), 32'd0);
        rst = 1'b1;

        $display("[TB] ready ADD");
        applyStimulus(OP_ADD, 32'd5, 32'd7, 3'd0, 3'd0, 3'd3, 32'd0);
        push(3'd3, 32'd12);
        tick(); checkOutput(1'b0, "add_e0");
        idle();
        tick(); checkOutput(1'b1, "add_e1");
        tick(); checkOutput(1'b0, "add_e2");

        $display("[TB] SUB waiting on memory tag");
        applyStimulus(OP_SUB, 32'd0, 32'd1, 3'd2, 3'd0, 3'd4, 32'd0);
        tick(); checkOutput(1'b0, "sub_d");
        idle();
        tick(); checkOutput(1'b0, "sub_w1");
        tick(); checkOutput(1'b0, "sub_w2");
        setMem(3'd2, 32'd10);
        push(3'd4, 32'd9);
        tick(); checkOutput(1'b0, "sub_snoop");
        setMem(3'd0, 32'd0);
        tick(); checkOutput(1'b1, "sub_issue");
        tick(); checkOutput(1'b0, "sub_after");

        $display("[TB] signed vs unsigned branch");
        applyStimulus(OP_BLT, 32'hFFFF_FFFF, 32'd1, 3'd0, 3'd0, 3'd5, 32'd0);
        push(3'd5, 32'd1);
        tick(); checkOutput(1'b0, "blt_d");
        applyStimulus(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 3'd0, 3'd0, 3'd6, 32'd0);
        push(3'd6, 32'd0);
        tick(); checkOutput(1'b1, "blt_i");
        idle();
        tick(); checkOutput(1'b1, "bltu_i");
        tick(); checkOutput(1'b0, "bltu_after");

        $display("[TB] back-to-back op table");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(t_op[i], t_a[i], t_b[i], 3'd0, 3'd0, 3'((i % 7) + 1), t_imm[i]);
            push(3'((i % 7) + 1), model(t_op[i], t_a[i], t_b[i], t_imm[i]));
            tick(); checkOutput(i > 0, "vec");
        end
        idle();
        tick(); checkOutput(1'b1, "vec_last");
        tick(); checkOutput(1'b0, "vec_after");

        $display("[TB] fill with dependents, rs_full");
        applyStimulus(OP_ADD, 32'd0, 32'd5, 3'd1, 3'd0, 3'd2, 32'd0);
        push(3'd2, 32'h15);
        tick(); check("full_w1", 32'(bus.rs_full), 32'd0); checkOutput(1'b0, "dep_w1");
        applyStimulus(OP_XOR, 32'd0, 32'hFF, 3'd1, 3'd0, 3'd3, 32'd0);
        push(3'd3, 32'hEF);
        tick(); check("full_w2", 32'(bus.rs_full), 32'd0);
        applyStimulus(OP_SLL, 32'd0, 32'd4, 3'd1, 3'd0, 3'd4, 32'd0);
        push(3'd4, 32'h100);
        tick(); check("full_w3", 32'(bus.rs_full), 32'd1);
        applyStimulus(OP_SRA, 32'd0, 32'd2, 3'd0, 3'd1, 3'd5, 32'd0);
        push(3'd5, 32'd0);
        tick(); check("full_w4", 32'(bus.rs_full), 32'd1); checkOutput(1'b0, "dep_w4");
        idle();
        setMem(3'd1, 32'h10);
        tick(); checkOutput(1'b0, "dep_snoop"); check("full_snoop", 32'(bus.rs_full), 32'd1);
        setMem(3'd0, 32'd0);
        tick(); checkOutput(1'b1, "dep_i1"); check("full_i1", 32'(bus.rs_full), 32'd1);
        tick(); checkOutput(1'b1, "dep_i2"); check("full_i2", 32'(bus.rs_full), 32'd0);
        tick(); checkOutput(1'b1, "dep_i3");
        tick(); checkOutput(1'b1, "dep_i4");
        tick(); checkOutput(1'b0, "dep_after");

        $display("[TB] same-edge capture from ALU bus");
        applyStimulus(OP_ADD, 32'd100, 32'd1, 3'd0, 3'd0, 3'd6, 32'd0);
        push(3'd6, 32'd101);
        tick(); checkOutput(1'b0, "cap_d");
        idle();
        tick(); checkOutput(1'b1, "cap_src");
        applyStimulus(OP_ADD, 32'd0, 32'd5, 3'd6, 3'd0, 3'd7, 32'd0);
        push(3'd7, 32'd106);
        tick(); checkOutput(1'b0, "cap_d2");
        idle();
        tick(); checkOutput(1'b1, "cap_issue");

        $display("[TB] flush");
        applyStimulus(OP_ADD, 32'd0, 32'd1, 3'd5, 3'd0, 3'd2, 32'd0);
        tick();
        applyStimulus(OP_OR, 32'd0, 32'd1, 3'd5, 3'd0, 3'd3, 32'd0);
        tick();
        applyStimulus(OP_ADD, 32'd1, 32'd1, 3'd0, 3'd0, 3'd1, 32'd0);
        tick(); check("flush_pre_full", 32'(bus.rs_full), 32'd1);
        applyStimulus(OP_ADD, 32'd2, 32'd2, 3'd0, 3'd0, 3'd4, 32'd0);
        bus.flush = 1'b1;
        tick(); checkOutput(1'b0, "flush_edge"); check("flush_full", 32'(bus.rs_full), 32'd0);
        bus.flush = 1'b0;
        idle();
        setMem(3'd5, 32'd9);
        tick(); checkOutput(1'b0, "flush_a1");
        setMem(3'd0, 32'd0);
        tick(); checkOutput(1'b0, "flush_a2");
        tick(); checkOutput(1'b0, "flush_a3");

        $display("[TB] overflow and mid-stream reset");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(OP_ADD, 32'd0, 32'd1, 3'd7, 3'd0, 3'(i + 1), 32'd0);
            tick();
        end
        idle();
        check("ovf_set", 32'(bus.rs_overflow), 32'd1);
        check("ovf_full", 32'(bus.rs_full), 32'd1);
        applyStimulus(OP_ADD, 32'd3, 32'd3, 3'd0, 3'd0, 3'd6, 32'd0);
        rst = 1'b0;
        tick();
        check("rst_num", 32'(bus.alu_num), 32'd0);
        check("rst_value", bus.alu_value, 32'd0);
        check("rst_full", 32'(bus.rs_full), 32'd0);
        check("rst_ovf", 32'(bus.rs_overflow), 32'd0);
        rst = 1'b1;
        idle();
        setMem(3'd7, 32'd1);
        tick(); checkOutput(1'b0, "rst_a1");
        setMem(3'd0, 32'd0);
        tick(); checkOutput(1'b0, "rst_a2");
        tick(); checkOutput(1'b0, "rst_a3");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
